// File: rtl/alu_lockstep_monitor.sv
// ============================================================================
// Module   : alu_lockstep_monitor
// Purpose  : Filters lockstep ALU syndromes, confirms persistent mismatches and
//            latches a sticky fault alarm. Optional macro ALU_FMON_TIMESTAMP_EN
//            adds a cycle timestamp of the confirmed streak.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_lockstep_monitor #(
    parameter int unsigned CONFIRM_CNT = 3,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TS_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chk_valid,
    input  logic [7:0]       x,
    input  logic             y,
    input  logic [1:0]       ALU_Sel1,
    input  logic [1:0]       ALU_Sel2,
    input  logic             fault_clr,
    output logic             fault_alarm,
    output logic [1:0]       mon_state,
    output logic [7:0]       syn_x,
    output logic             syn_y,
    output logic [3:0]       syn_sel,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] glitch_cnt,
    output logic [TS_W-1:0]  fault_ts
);

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_SUSPECT = 2'b01,
        ST_FAULT   = 2'b10
    } state_t;

    localparam logic [4:0]       c_confirm = 5'(CONFIRM_CNT);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t           r_state;
    logic [3:0]       r_streak;
    logic             r_alarm;
    logic [7:0]       r_syn_x;
    logic             r_syn_y;
    logic [3:0]       r_syn_sel;
    logic [CNT_W-1:0] r_mismatch_cnt;
    logic [CNT_W-1:0] r_glitch_cnt;

    logic             w_mismatch;
    logic [4:0]       w_streak_inc;

    assign w_mismatch   = (x != 8'h00) | y;
    assign w_streak_inc = {1'b0, r_streak} + 5'd1;

`ifdef ALU_FMON_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts_cnt;
    logic [TS_W-1:0] r_fault_ts;

    // Free-running; deliberately unaffected by fault_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts_cnt <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 1'b1;
        end
    end

    assign fault_ts = r_fault_ts;
`else
    assign fault_ts = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_OK;
            r_streak       <= 4'd0;
            r_alarm        <= 1'b0;
            r_syn_x        <= 8'h00;
            r_syn_y        <= 1'b0;
            r_syn_sel      <= 4'h0;
            r_mismatch_cnt <= '0;
            r_glitch_cnt   <= '0;
`ifdef ALU_FMON_TIMESTAMP_EN
            r_fault_ts     <= '0;
`endif
        end else if (fault_clr) begin
            // Clear wins over a coincident sample, which is dropped uncounted.
            r_state        <= ST_OK;
            r_streak       <= 4'd0;
            r_alarm        <= 1'b0;
            r_syn_x        <= 8'h00;
            r_syn_y        <= 1'b0;
            r_syn_sel      <= 4'h0;
            r_mismatch_cnt <= '0;
            r_glitch_cnt   <= '0;
`ifdef ALU_FMON_TIMESTAMP_EN
            r_fault_ts     <= '0;
`endif
        end else if (chk_valid) begin
            if (w_mismatch && (r_mismatch_cnt != c_cnt_max)) begin
                r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
            end

            case (r_state)
                ST_OK: begin
                    if (w_mismatch) begin
                        r_syn_x   <= x;
                        r_syn_y   <= y;
                        r_syn_sel <= {ALU_Sel1, ALU_Sel2};
                        r_streak  <= 4'd1;
`ifdef ALU_FMON_TIMESTAMP_EN
                        r_fault_ts <= r_ts_cnt;
`endif
                        if (c_confirm == 5'd1) begin
                            r_state <= ST_FAULT;
                            r_alarm <= 1'b1;
                        end else begin
                            r_state <= ST_SUSPECT;
                        end
                    end
                end

                ST_SUSPECT: begin
                    if (w_mismatch) begin
                        r_streak <= w_streak_inc[3:0];
                        if (w_streak_inc == c_confirm) begin
                            r_state <= ST_FAULT;
                            r_alarm <= 1'b1;
                        end
                    end else begin
                        r_state  <= ST_OK;
                        r_streak <= 4'd0;
                        if (r_glitch_cnt != c_cnt_max) begin
                            r_glitch_cnt <= r_glitch_cnt + 1'b1;
                        end
                    end
                end

                ST_FAULT: begin
                    r_alarm <= 1'b1;
                end

                default: begin
                    r_state  <= ST_OK;
                    r_streak <= 4'd0;
                    r_alarm  <= 1'b0;
                end
            endcase
        end
    end

    assign fault_alarm  = r_alarm;
    assign mon_state    = r_state;
    assign syn_x        = r_syn_x;
    assign syn_y        = r_syn_y;
    assign syn_sel      = r_syn_sel;
    assign mismatch_cnt = r_mismatch_cnt;
    assign glitch_cnt   = r_glitch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_lockstep_monitor.sv
// ============================================================================
// Module   : tb_alu_lockstep_monitor
// Purpose  : Directed-vector scoreboard bench for alu_lockstep_monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_lockstep_monitor;

    localparam int unsigned CW = 4;
    localparam int unsigned TW = 16;

    logic          clk;
    logic          rst_n;
    logic          chk_valid;
    logic [7:0]    x;
    logic          y;
    logic [1:0]    ALU_Sel1;
    logic [1:0]    ALU_Sel2;
    logic          fault_clr;
    logic          fault_alarm;
    logic [1:0]    mon_state;
    logic [7:0]    syn_x;
    logic          syn_y;
    logic [3:0]    syn_sel;
    logic [CW-1:0] mismatch_cnt;
    logic [CW-1:0] glitch_cnt;
    logic [TW-1:0] fault_ts;

    alu_lockstep_monitor #(
        .CONFIRM_CNT (3),
        .CNT_W       (CW),
        .TS_W        (TW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .chk_valid    (chk_valid),
        .x            (x),
        .y            (y),
        .ALU_Sel1     (ALU_Sel1),
        .ALU_Sel2     (ALU_Sel2),
        .fault_clr    (fault_clr),
        .fault_alarm  (fault_alarm),
        .mon_state    (mon_state),
        .syn_x        (syn_x),
        .syn_y        (syn_y),
        .syn_sel      (syn_sel),
        .mismatch_cnt (mismatch_cnt),
        .glitch_cnt   (glitch_cnt),
        .fault_ts     (fault_ts)
    );

    typedef struct {
        logic [1:0]    st;
        logic [7:0]    sx;
        logic          sy;
        logic [3:0]    ssel;
        logic [CW-1:0] m;
        logic [CW-1:0] g;
        logic [TW-1:0] ts;
        bit            ts_chk;
        int            idx;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec    = 0;
    logic [TW-1:0] exp_ts;
    bit            exp_ts_chk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, int id, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec=%0d got=%0h expected=%0h", name, id, act, req);
        end
    endfunction

    function automatic logic [CW-1:0] sat(int v);
        return (v > 15) ? 4'hF : 4'(v);
    endfunction

    // Monitor: one expectation per clock edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state", e.idx, 32'(mon_state), 32'(e.st));
                chk("alarm", e.idx, 32'(fault_alarm), 32'(e.st == 2'b10));
                chk("syn", e.idx, {19'd0, syn_y, syn_sel, syn_x}, {19'd0, e.sy, e.ssel, e.sx});
                chk("mismatch_cnt", e.idx, 32'(mismatch_cnt), 32'(e.m));
                chk("glitch_cnt", e.idx, 32'(glitch_cnt), 32'(e.g));
                if (e.ts_chk) chk("fault_ts", e.idx, 32'(fault_ts), 32'(e.ts));
            end
        end
    end

    task automatic cyc(input bit v, input logic [7:0] xx, input bit yy,
                       input logic [1:0] s1, input logic [1:0] s2, input bit clr,
                       input logic [1:0] est, input logic [7:0] esx, input bit esy,
                       input logic [3:0] essel, input logic [CW-1:0] em,
                       input logic [CW-1:0] eg);
        exp_t e;
        @(negedge clk);
        chk_valid = v;
        x         = xx;
        y         = yy;
        ALU_Sel1  = s1;
        ALU_Sel2  = s2;
        fault_clr = clr;
        e.st = est; e.sx = esx; e.sy = esy; e.ssel = essel;
        e.m = em; e.g = eg; e.ts = exp_ts; e.ts_chk = exp_ts_chk;
        e.idx = vec++;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; chk_valid = 1'b0; x = 8'h00; y = 1'b0;
        ALU_Sel1 = 2'b00; ALU_Sel2 = 2'b00; fault_clr = 1'b0;
        exp_ts = '0;
`ifdef ALU_FMON_TIMESTAMP_EN
        exp_ts_chk = 1'b0;
`else
        exp_ts_chk = 1'b1;
`endif
        #7;
        chk("reset_state", -1, 32'(mon_state), 32'd0);
        chk("reset_alarm", -1, 32'(fault_alarm), 32'd0);
        chk("reset_cnts", -1, {mismatch_cnt, glitch_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean traffic
        repeat (10) cyc(1, 8'h00, 0, 2'd0, 2'd0, 0, 2'b00, 8'h00, 0, 4'h0, 4'd0, 4'd0);

        // Three consecutive mismatches confirm a fault
        cyc(1, 8'h04, 0, 2'd1, 2'd1, 0, 2'b01, 8'h04, 0, 4'b0101, 4'd1, 4'd0);
        cyc(1, 8'h10, 0, 2'd1, 2'd1, 0, 2'b01, 8'h04, 0, 4'b0101, 4'd2, 4'd0);
        cyc(1, 8'h01, 0, 2'd1, 2'd1, 0, 2'b10, 8'h04, 0, 4'b0101, 4'd3, 4'd0);

        // FAULT absorbs further mismatches; clear beats a coincident sample
        cyc(1, 8'h80, 0, 2'd2, 2'd3, 0, 2'b10, 8'h04, 0, 4'b0101, 4'd4, 4'd0);
        cyc(1, 8'h00, 1, 2'd0, 2'd0, 0, 2'b10, 8'h04, 0, 4'b0101, 4'd5, 4'd0);
        cyc(1, 8'h00, 0, 2'd0, 2'd0, 0, 2'b10, 8'h04, 0, 4'b0101, 4'd5, 4'd0);
        cyc(1, 8'hFF, 1, 2'd3, 2'd3, 1, 2'b00, 8'h00, 0, 4'h0, 4'd0, 4'd0);

        // Carry-only mismatch, invalid gap holds everything, then recovery
        cyc(1, 8'h00, 1, 2'd2, 2'd1, 0, 2'b01, 8'h00, 1, 4'b1001, 4'd1, 4'd0);
        repeat (5) cyc(0, 8'h55, 1, 2'd3, 2'd3, 0, 2'b01, 8'h00, 1, 4'b1001, 4'd1, 4'd0);
        cyc(1, 8'h00, 0, 2'd0, 2'd0, 0, 2'b00, 8'h00, 1, 4'b1001, 4'd1, 4'd1);

        // Streak of CONFIRM_CNT-1 recovers; next streak restarts from one
        cyc(1, 8'h02, 0, 2'd0, 2'd0, 0, 2'b01, 8'h02, 0, 4'h0, 4'd2, 4'd1);
        cyc(1, 8'h03, 0, 2'd0, 2'd0, 0, 2'b01, 8'h02, 0, 4'h0, 4'd3, 4'd1);
        cyc(1, 8'h00, 0, 2'd0, 2'd0, 0, 2'b00, 8'h02, 0, 4'h0, 4'd3, 4'd2);
        cyc(1, 8'h20, 0, 2'd3, 2'd0, 0, 2'b01, 8'h20, 0, 4'b1100, 4'd4, 4'd2);
        cyc(1, 8'h21, 0, 2'd0, 2'd0, 0, 2'b01, 8'h20, 0, 4'b1100, 4'd5, 4'd2);
        cyc(1, 8'h22, 0, 2'd0, 2'd0, 0, 2'b10, 8'h20, 0, 4'b1100, 4'd6, 4'd2);

        // 2^CW+2 further mismatches: mismatch_cnt saturates at 4'hF
        for (int i = 0; i < 18; i++)
            cyc(1, 8'h40, 0, 2'd0, 2'd0, 0, 2'b10, 8'h20, 0, 4'b1100, sat(7 + i), 4'd2);
        cyc(0, 8'h00, 0, 2'd0, 2'd0, 1, 2'b00, 8'h00, 0, 4'h0, 4'd0, 4'd0);

        // 17 single-sample glitches: glitch_cnt saturates too
        for (int i = 0; i < 17; i++) begin
            cyc(1, 8'h01, 0, 2'd0, 2'd0, 0, 2'b01, 8'h01, 0, 4'h0, sat(i + 1), sat(i));
            cyc(1, 8'h00, 0, 2'd0, 2'd0, 0, 2'b00, 8'h01, 0, 4'h0, sat(i + 1), sat(i + 1));
        end

        // Clear from SUSPECT
        cyc(1, 8'h08, 0, 2'd0, 2'd0, 0, 2'b01, 8'h08, 0, 4'h0, 4'hF, 4'hF);
        cyc(0, 8'h00, 0, 2'd0, 2'd0, 1, 2'b00, 8'h00, 0, 4'h0, 4'd0, 4'd0);

        // Asynchronous reset between edges while in SUSPECT
        cyc(1, 8'h40, 0, 2'd1, 2'd2, 0, 2'b01, 8'h40, 0, 4'b0110, 4'd1, 4'd0);
        @(posedge clk);
        #3;
        chk_valid = 1'b0; x = 8'h00; y = 1'b0; fault_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", -2, {29'd0, fault_alarm, mon_state}, 32'd0);
        chk("async_rst_syn", -2, {19'd0, syn_y, syn_sel, syn_x}, 32'd0);
        chk("async_rst_cnts", -2, {mismatch_cnt, glitch_cnt}, 32'd0);
        chk("async_rst_ts", -2, 32'(fault_ts), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Timestamp: first post-reset edge is cycle 0, mismatch lands on cycle 20
        repeat (19) cyc(1, 8'h00, 0, 2'd0, 2'd0, 0, 2'b00, 8'h00, 0, 4'h0, 4'd0, 4'd0);
`ifdef ALU_FMON_TIMESTAMP_EN
        exp_ts = 16'd20;
        exp_ts_chk = 1'b1;
`endif
        cyc(1, 8'h09, 0, 2'd2, 2'd2, 0, 2'b01, 8'h09, 0, 4'b1010, 4'd1, 4'd0);
        cyc(1, 8'h09, 0, 2'd0, 2'd0, 0, 2'b01, 8'h09, 0, 4'b1010, 4'd2, 4'd0);
        cyc(1, 8'h09, 0, 2'd0, 2'd0, 0, 2'b10, 8'h09, 0, 4'b1010, 4'd3, 4'd0);
        cyc(1, 8'h09, 0, 2'd0, 2'd0, 0, 2'b10, 8'h09, 0, 4'b1010, 4'd4, 4'd0);

        begin
            int budget;
            budget = 20;
            while (q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            #3;
            if (q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain pending=%0d expected=0", q.size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
